// File: rtl/phase_sweep_pkg.sv
// rtl/phase_sweep_pkg.sv - shared state encoding and saturating adder for the phase sweep scheduler
package phase_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_RECORD  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Adds two nb-bit values (nb <= 64); a carry out of bit nb-1 clamps to all-ones.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned nb);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = 65'd1 << nb;
        if (sum >= lim) begin
            return 64'(lim - 65'd1);
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - down-counter shared by the CLEAR, SETTLE and MEASURE phases
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_value,
    input  logic         i_enable,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Load value is cycles-1, so o_expired rises in the last cycle of the interval.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/phase_sweep_ctrl.sv
// rtl/phase_sweep_ctrl.sv - sweeps RX sampling phase, measures BER per phase and applies the best one
module phase_sweep_ctrl
    import phase_sweep_pkg::*;
#(
    parameter int NB_BER        = 64,
    parameter int NB_OFFSET     = 2,
    parameter int CLR_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int MEAS_BITS     = 1024,
    parameter int TIMEOUT       = 2**20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NB_BER-1:0]    i_bit_count,
    input  logic [NB_BER-1:0]    i_err_count_i,
    input  logic [NB_BER-1:0]    i_err_count_q,
    output logic [NB_OFFSET-1:0] o_offset,
    output logic                 o_ber_clear,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [NB_OFFSET-1:0] o_best_offset,
    output logic [NB_BER-1:0]    o_best_errors
);

    localparam int TMR_MAX0 = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int TMR_MAX  = (TMR_MAX0 > TIMEOUT) ? TMR_MAX0 : TIMEOUT;
    localparam int TW       = $clog2(TMR_MAX + 1);

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_start_d;
    logic [NB_OFFSET-1:0]   r_cur;
    logic [NB_OFFSET-1:0]   r_best_off;
    logic [NB_OFFSET-1:0]   r_applied;
    logic [NB_OFFSET-1:0]   r_offset;
    logic [NB_OFFSET-1:0]   r_best_offset;
    logic [NB_BER-1:0]      r_best_err;
    logic [NB_BER-1:0]      r_best_errors;
    logic                   r_ber_clear;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_timeout;
    logic                   r_phase_to;

    logic                   w_start_edge;
    logic                   w_bits_done;
    logic                   w_tmr_expired;
    logic                   w_tmr_load;
    logic                   w_tmr_en;
    logic [TW-1:0]          w_tmr_value;
    logic [63:0]            w_sum64;
    logic [NB_BER-1:0]      w_rec_err;
    logic                   w_better;
    logic [NB_BER-1:0]      w_best_err_nxt;
    logic [NB_OFFSET-1:0]   w_best_off_nxt;

    cycle_timer #(.W(TW)) u_timer (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .i_enable     (w_tmr_en),
        .o_expired    (w_tmr_expired)
    );

    // Sampled without reset so a start level held through reset never looks like an edge.
    always_ff @(posedge clock) begin
        r_start_d <= i_start;
    end

    assign w_start_edge = i_start && !r_start_d;
    assign w_bits_done  = (i_bit_count >= NB_BER'(MEAS_BITS));
    assign w_tmr_en     = (r_state == ST_CLEAR) || (r_state == ST_SETTLE) || (r_state == ST_MEASURE);

    assign w_sum64        = sat_add(64'(i_err_count_i), 64'(i_err_count_q), NB_BER);
    assign w_rec_err      = r_phase_to ? '1 : w_sum64[NB_BER-1:0];
    assign w_better       = (w_rec_err < r_best_err);
    assign w_best_err_nxt = w_better ? w_rec_err : r_best_err;
    assign w_best_off_nxt = w_better ? r_cur : r_best_off;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_edge) w_next = ST_CLEAR;
            ST_CLEAR:   if (w_tmr_expired) w_next = ST_SETTLE;
            ST_SETTLE:  if (w_tmr_expired) w_next = ST_MEASURE;
            ST_MEASURE: if (w_bits_done || w_tmr_expired) w_next = ST_RECORD;
            ST_RECORD:  w_next = (r_cur == '1) ? ST_DONE : ST_CLEAR;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
        if (i_abort) begin
            w_next = ST_IDLE;
        end
    end

    always_comb begin
        w_tmr_load  = (w_next != r_state) &&
                      ((w_next == ST_CLEAR) || (w_next == ST_SETTLE) || (w_next == ST_MEASURE));
        w_tmr_value = TW'(CLR_CYCLES - 1);
        if (w_next == ST_SETTLE) begin
            w_tmr_value = TW'(SETTLE_CYCLES - 1);
        end else if (w_next == ST_MEASURE) begin
            w_tmr_value = TW'(TIMEOUT - 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cur         <= '0;
            r_best_off    <= '0;
            r_applied     <= '0;
            r_offset      <= '0;
            r_best_offset <= '0;
            r_best_err    <= '1;
            r_best_errors <= '1;
            r_ber_clear   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_phase_to    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ber_clear <= (w_next == ST_CLEAR);
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_next == ST_CLEAR) begin
                        r_cur      <= '0;
                        r_offset   <= '0;
                        r_best_err <= '1;
                        r_best_off <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (w_next == ST_RECORD) begin
                        r_phase_to <= !w_bits_done;
                        if (!w_bits_done) r_timeout <= 1'b1;
                    end
                end
                ST_RECORD: begin
                    r_best_err <= w_best_err_nxt;
                    r_best_off <= w_best_off_nxt;
                    if (w_next == ST_CLEAR) begin
                        r_cur    <= r_cur + 1'b1;
                        r_offset <= r_cur + 1'b1;
                    end else if (w_next == ST_DONE) begin
                        r_offset      <= w_best_off_nxt;
                        r_applied     <= w_best_off_nxt;
                        r_best_offset <= w_best_off_nxt;
                        r_best_errors <= w_best_err_nxt;
                    end
                end
                default: ;
            endcase
            // Abort falls back to the last applied result.
            if (i_abort && (r_state != ST_IDLE)) begin
                r_offset <= r_applied;
            end
        end
    end

    assign o_offset      = r_offset;
    assign o_ber_clear   = r_ber_clear;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_best_offset = r_best_offset;
    assign o_best_errors = r_best_errors;

endmodule
